// File: rtl/png_chunk_ctl.sv
// PNG chunk sequencer: frames length, type, payload and CRC words around an
// external 4-cycle-per-word CRC engine, with a one-deep ready/valid output register.
module png_chunk_ctl #(
  parameter int LEN_WD = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [LEN_WD-1:0] len_i,
  input  logic [31:0]       typ_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              val_i,
  input  logic [31:0]       dat_i,
  output logic              rdy_o,
  output logic              val_o,
  output logic [31:0]       dat_o,
  output logic              lst_o,
  input  logic              rdy_i,
  output logic              done_o,
  output logic              crc_start_o,
  output logic              crc_val_o,
  output logic [31:0]       crc_dat_o,
  output logic              crc_lst_o,
  input  logic [31:0]       crc_dat_i
);

  localparam int CNT_WD = LEN_WD - 2;

  typedef enum logic [2:0] {IDLE, LEN, TYP, DAT, WAIT, CRC} state_t;

  state_t            state_reg, state_next;
  logic [CNT_WD-1:0] rem_reg, rem_next;
  logic [31:0]       typ_reg, typ_next;
  logic [2:0]        slot_reg, slot_next;
  logic              out_val_reg, out_val_next;
  logic [31:0]       out_dat_reg, out_dat_next;
  logic              out_lst_reg, out_lst_next;
  logic              crc_val_reg, crc_val_next;
  logic              crc_lst_reg, crc_lst_next;
  logic [31:0]       crc_dat_reg, crc_dat_next;
  logic              err_reg, err_next;

  logic hs, can_load, slot_free;

  // slot_reg is 4 in the feed cycle: a new feed may load once it reaches 1,
  // the engine result is usable once it reaches 0.
  assign hs        = out_val_reg && rdy_i;
  assign can_load  = !out_val_reg || rdy_i;
  assign slot_free = (slot_reg <= 3'd1);

  always_comb begin
    state_next   = state_reg;
    rem_next     = rem_reg;
    typ_next     = typ_reg;
    slot_next    = (slot_reg != 3'd0) ? slot_reg - 3'd1 : 3'd0;
    out_val_next = hs ? 1'b0 : out_val_reg;
    out_dat_next = out_dat_reg;
    out_lst_next = out_lst_reg;
    crc_val_next = 1'b0;
    crc_lst_next = 1'b0;
    crc_dat_next = crc_dat_reg;
    err_next     = 1'b0;
    crc_start_o  = 1'b0;
    rdy_o        = 1'b0;
    done_o       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (len_i[1:0] == 2'b00) begin
            crc_start_o  = 1'b1;
            rem_next     = len_i[LEN_WD-1:2];
            typ_next     = typ_i;
            out_val_next = 1'b1;
            out_dat_next = 32'(len_i);
            out_lst_next = 1'b0;
            state_next   = LEN;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LEN: begin
        if (hs && slot_free) begin
          out_val_next = 1'b1;
          out_dat_next = typ_reg;
          out_lst_next = 1'b0;
          crc_val_next = 1'b1;
          crc_dat_next = typ_reg;
          crc_lst_next = (rem_reg == '0);
          slot_next    = 3'd4;
          state_next   = TYP;
        end
      end
      TYP: begin
        state_next = (rem_reg != '0) ? DAT : WAIT;
      end
      DAT: begin
        rdy_o = can_load && slot_free && (rem_reg != '0);
        if (val_i && rdy_o) begin
          out_val_next = 1'b1;
          out_dat_next = dat_i;
          out_lst_next = 1'b0;
          crc_val_next = 1'b1;
          crc_dat_next = dat_i;
          crc_lst_next = (rem_reg == CNT_WD'(1));
          slot_next    = 3'd4;
          rem_next     = rem_reg - CNT_WD'(1);
          if (rem_reg == CNT_WD'(1)) state_next = WAIT;
        end
      end
      WAIT: begin
        if (can_load && (slot_reg == 3'd0)) begin
          out_val_next = 1'b1;
          out_dat_next = crc_dat_i;
          out_lst_next = 1'b1;
          state_next   = CRC;
        end
      end
      CRC: begin
        if (hs) begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      typ_reg     <= '0;
      slot_reg    <= 3'd0;
      out_val_reg <= 1'b0;
      out_dat_reg <= '0;
      out_lst_reg <= 1'b0;
      crc_val_reg <= 1'b0;
      crc_lst_reg <= 1'b0;
      crc_dat_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rem_reg     <= rem_next;
      typ_reg     <= typ_next;
      slot_reg    <= slot_next;
      out_val_reg <= out_val_next;
      out_dat_reg <= out_dat_next;
      out_lst_reg <= out_lst_next;
      crc_val_reg <= crc_val_next;
      crc_lst_reg <= crc_lst_next;
      crc_dat_reg <= crc_dat_next;
      err_reg     <= err_next;
    end
  end

  assign busy_o    = (state_reg != IDLE);
  assign err_o     = err_reg;
  assign val_o     = out_val_reg;
  assign dat_o     = out_dat_reg;
  assign lst_o     = out_lst_reg;
  assign crc_val_o = crc_val_reg;
  assign crc_lst_o = crc_lst_reg;
  assign crc_dat_o = crc_dat_reg;

endmodule

// File: tb/tb_png_chunk_ctl.sv
// Scoreboard bench for png_chunk_ctl with a byte-serial CRC engine model that
// consumes one byte of crc_dat_o per cycle and publishes its result 4 cycles after the feed.
module tb_png_chunk_ctl;

  logic        clk, rstn;
  logic        start_i;
  logic [15:0] len_i;
  logic [31:0] typ_i;
  logic        busy_o, err_o;
  logic        val_i;
  logic [31:0] dat_i;
  logic        rdy_o, val_o, lst_o, rdy_i, done_o;
  logic [31:0] dat_o;
  logic        crc_start_o, crc_val_o, crc_lst_o;
  logic [31:0] crc_dat_o, crc_dat_i;

  png_chunk_ctl #(.LEN_WD(16)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .typ_i(typ_i),
    .busy_o(busy_o), .err_o(err_o), .val_i(val_i), .dat_i(dat_i), .rdy_o(rdy_o),
    .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o), .rdy_i(rdy_i), .done_o(done_o),
    .crc_start_o(crc_start_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o),
    .crc_lst_o(crc_lst_o), .crc_dat_i(crc_dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] dat; logic lst; int cyc; } exp_t;
  typedef struct { int cyc; logic lst; } feed_t;

  exp_t        sb_q[$];
  feed_t       feed_q[$];
  logic        feed_chk;
  int          n_checks, n_pass;
  int          cyc, t0;
  logic [31:0] pay [0:15];
  logic [31:0] eng_crc, eng_pub, eng_hold;
  logic        eng_pend;
  int          eng_ph;
  logic        stall_pend;
  logic [33:0] stall_word;

  wire [72:0] out_vec = {busy_o, err_o, rdy_o, val_o, dat_o, lst_o, done_o,
                         crc_start_o, crc_val_o, crc_dat_o, crc_lst_o};

  assign crc_dat_i = ~eng_pub;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [31:0] golden_crc(input logic [31:0] typ, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int b = 3; b >= 0; b--) c = crc_byte(c, typ[8*b +: 8]);
    for (int i = 0; i < n; i++)
      for (int b = 3; b >= 0; b--) c = crc_byte(c, pay[i][8*b +: 8]);
    return ~c;
  endfunction

  // Engine model: byte k of the fed word is consumed at the falling edge of f+k.
  initial begin
    eng_crc = '0; eng_pub = 32'hFFFFFFFF; eng_hold = '0; eng_pend = 0; eng_ph = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        eng_ph = 0; eng_pend = 0; eng_pub = 32'hFFFFFFFF;
      end else begin
        if (eng_pend) begin
          eng_pub  = eng_crc;
          eng_pend = 0;
        end
        if (crc_start_o) begin
          eng_crc = 32'hFFFFFFFF; eng_pub = 32'hFFFFFFFF; eng_ph = 0; eng_pend = 0;
        end
        if (crc_val_o) begin
          if (eng_ph != 0) check("feed_spacing", eng_ph, 0);
          eng_hold = crc_dat_o;
          eng_crc  = crc_byte(eng_crc, crc_dat_o[31:24]);
          eng_ph   = 1;
        end else if (eng_ph != 0) begin
          check("crc_dat_hold", crc_dat_o, eng_hold);
          eng_crc = crc_byte(eng_crc, crc_dat_o[8*(3-eng_ph) +: 8]);
          eng_ph++;
          if (eng_ph == 4) begin
            eng_ph   = 0;
            eng_pend = 1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and engine feed.
  initial begin
    stall_pend = 0; stall_word = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall_pend = 0;
      end else begin
        if (stall_pend) check("stall_hold", {val_o, lst_o, dat_o}, stall_word);
        if (val_o && rdy_i) begin
          $display("out word %h lst %0b cycle %0d", dat_o, lst_o, cyc - t0);
          if (sb_q.size() == 0) begin
            check("unexpected_word", 0, 1);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("out_dat", dat_o, e.dat);
            check("out_lst", lst_o, e.lst);
            check("done_pulse", done_o, e.lst);
            if (e.cyc >= 0) check("out_cycle", cyc - t0, e.cyc);
          end
        end
        if (done_o) check("done_only_on_crc", val_o && rdy_i && lst_o, 1);
        if (crc_val_o && feed_chk) begin
          if (feed_q.size() == 0) begin
            check("unexpected_feed", 0, 1);
          end else begin
            feed_t f;
            f = feed_q.pop_front();
            check("feed_cycle", cyc - t0, f.cyc);
            check("feed_lst", crc_lst_o, f.lst);
          end
        end
        stall_pend = val_o && !rdy_i;
        stall_word = {val_o, lst_o, dat_o};
      end
    end
  end

  task automatic push_chunk(input int len, input logic [31:0] typ, input bit timed);
    int n;
    n = len / 4;
    sb_q.push_back('{32'(len), 1'b0, timed ? 1 : -1});
    sb_q.push_back('{typ, 1'b0, timed ? 2 : -1});
    for (int i = 0; i < n; i++) sb_q.push_back('{pay[i], 1'b0, timed ? 6 + 4*i : -1});
    sb_q.push_back('{golden_crc(typ, n), 1'b1, timed ? 7 + 4*n : -1});
    feed_chk = timed;
    if (timed) begin
      feed_q.push_back('{2, n == 0});
      for (int i = 0; i < n; i++) feed_q.push_back('{6 + 4*i, i == n-1});
    end
  endtask

  task automatic start_chunk(input int len, input logic [31:0] typ);
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 16'(len); typ_i = typ; t0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_words(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int k;
      if (gaps) repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      val_i = 1'b1; dat_i = pay[i];
      k = 0;
      @(negedge clk);
      while (!rdy_o && k < 400) begin @(negedge clk); k++; end
      check("payload_accept", rdy_o, 1);
      @(posedge clk); #1;
      val_i = 1'b0;
    end
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin @(negedge clk); k++; end
    check("chunk_complete", sb_q.size(), 0);
    if (feed_chk) check("feeds_complete", feed_q.size(), 0);
    @(negedge clk);
    check("idle_after_chunk", busy_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; t0 = 0; feed_chk = 0;
    rstn = 1'b0; start_i = 0; len_i = '0; typ_i = '0; val_i = 0; dat_i = '0; rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // IEND, no payload
    push_chunk(0, 32'h49454E44, 1);
    sb_q[2].dat = 32'hAE426082;
    start_chunk(0, 32'h49454E44);
    wait_empty(100);

    // 8-byte payload, full throughput
    pay[0] = 32'h11223344; pay[1] = 32'h55667788;
    push_chunk(8, 32'h49444154, 1);
    start_chunk(8, 32'h49444154);
    send_words(2, 0);
    wait_empty(100);

    // 64-byte chunk with random backpressure and input gaps
    for (int i = 0; i < 16; i++) pay[i] = $urandom;
    push_chunk(64, 32'h49444154, 0);
    start_chunk(64, 32'h49444154);
    fork
      send_words(16, 1);
      for (int k = 0; k < 3000 && sb_q.size() != 0; k++) begin
        @(posedge clk); #1;
        rdy_i = 1'($urandom_range(0, 1));
      end
    join
    rdy_i = 1'b1;
    wait_empty(200);

    // bad length
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 16'd6; typ_i = 32'h74455874;
    @(negedge clk);
    check("bad_len_no_crc_start", crc_start_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("bad_len_err", {err_o, busy_o, val_o}, 3'b100);
    @(negedge clk);
    check("bad_len_err_pulse", {err_o, busy_o, val_o}, 3'b000);

    // start while busy is ignored
    pay[0] = 32'hDEADBEEF; pay[1] = 32'h01020304;
    push_chunk(8, 32'h74455874, 1);
    start_chunk(8, 32'h74455874);
    fork
      send_words(2, 0);
      begin
        repeat (3) @(posedge clk);
        #1; start_i = 1'b1; len_i = 16'd4; typ_i = 32'h49454E44;
        @(posedge clk); #1; start_i = 1'b0;
      end
    join
    wait_empty(100);

    // reset mid-DAT
    pay[0] = 32'hCAFEF00D;
    sb_q.push_back('{32'd16, 1'b0, 1});
    sb_q.push_back('{32'h49444154, 1'b0, 2});
    sb_q.push_back('{pay[0], 1'b0, 6});
    feed_chk = 1;
    feed_q.push_back('{2, 1'b0});
    feed_q.push_back('{6, 1'b0});
    start_chunk(16, 32'h49444154);
    val_i = 1'b1; dat_i = pay[0];
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    check("pre_reset_words", sb_q.size(), 0);
    @(posedge clk); #1;
    val_i = 1'b0;
    rstn = 1'b0;
    #1;
    check("abort_outputs", out_vec, 0);
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    check("feeds_before_reset", feed_q.size(), 0);
    push_chunk(0, 32'h49454E44, 1);
    sb_q[2].dat = 32'hAE426082;
    start_chunk(0, 32'h49454E44);
    wait_empty(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
